pll_seq_ctrl: RTL and testbench
===============================

Name: pll_seq_ctrl

Overview:
Sequences the board PLL (SB_PLL40_CORE) from power-up to a stable system clock and gates the system reset until lock is trusted. Runs on the raw reference clock, not the PLL output, so it keeps working when the PLL is unlocked. It drives the PLL RESETB and BYPASS pins, monitors LOCK, and retries on timeout. After exhausted retries it falls back to bypass. Status is exported to DEBUG pins.

Parameters:
PLL_RST_CYCLES, 16, CLK cycles PLL_RESETB is held low per attempt (>=1)
LOCK_TIMEOUT, 1200, CLK cycles allowed for synced lock to rise (100 us at 12 MHz)
STABLE_CYCLES, 256, consecutive synced-lock-high cycles required before release
LOCK_FILT, 4, consecutive synced-lock-low cycles in RUN treated as lock loss
MAX_RETRIES, 3, timeouts tolerated before FAULT (total attempts = MAX_RETRIES+1)

Ports:
CLK  input  1  reference clock; all logic on rising edge
RESETB  input  1  asynchronous active-low reset
PLL_LOCK  input  1  LOCK from PLL, asynchronous to CLK
PLL_RESETB  output  1  to PLL RESETB, active low
PLL_BYPASS  output  1  to PLL BYPASS
SYS_RSTN  output  1  active-low reset request to sysclk-domain logic
PLL_READY  output  1  high only in RUN
FAULT  output  1  high only in FAULT
RETRY_CNT  output  2  timeouts in current bring-up sequence
STATE  output  3  current state encoding, for DEBUG pins

Behaviour:
- Reset: async assert, sync deassert inside block not required (RESETB is pre-synchronised externally). While RESETB=0: state=RESET_PLL, all counters 0, PLL_RESETB=0, PLL_BYPASS=0, SYS_RSTN=0, PLL_READY=0, FAULT=0, RETRY_CNT=0.
- PLL_LOCK passes through a 2-flop synchroniser (lock_s). Synchroniser flops reset to 0. Only lock_s is used by the FSM.
- All outputs are registered and change on the same edge as the state register.
- Encoding: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4. Values 5-7 are illegal and return to RESET_PLL next cycle.
- RESET_PLL:
  - PLL_RESETB=0, SYS_RSTN=0.
  - Counter counts PLL_RST_CYCLES cycles, then enters WAIT_LOCK with counter cleared.
  - PLL_RESETB is therefore low exactly PLL_RST_CYCLES cycles after RESETB release.
- WAIT_LOCK:
  - PLL_RESETB=1.
  - lock_s=1 -> STABILIZE with counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0: if RETRY_CNT==MAX_RETRIES -> FAULT; else RETRY_CNT+1 and go to RESET_PLL.
  - If lock_s rises on the timeout cycle, lock wins.
- STABILIZE:
  - Counter counts cycles with lock_s=1.
  - Any lock_s=0 -> RESET_PLL with RETRY_CNT+1, or FAULT if already at MAX_RETRIES.
  - After STABLE_CYCLES consecutive high cycles -> RUN.
- RUN:
  - SYS_RSTN=1, PLL_READY=1, RETRY_CNT cleared on entry.
  - Filter counter counts consecutive lock_s=0 cycles and clears on any lock_s=1.
  - Reaching LOCK_FILT -> RESET_PLL; SYS_RSTN=0 and PLL_READY=0 on that same edge.
  - Shorter glitches are ignored.
- FAULT:
  - PLL_BYPASS=1, PLL_RESETB=0, FAULT=1, SYS_RSTN=1 (system runs on bypassed reference clock), PLL_READY=0.
  - Terminal until RESETB asserts.
- RETRY_CNT saturates; never wraps. Counter widths are sized to the largest parameter (clog2).
- RESETB asserted in any state, including mid-count: immediate return to reset values, no partial state retained.

Test Plan (bench params: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOCK_FILT=3, MAX_RETRIES=2):
1. Nominal bring-up: release RESETB, raise PLL_LOCK at cycle 10 and hold -> PLL_RESETB rises at cycle 4; STATE 1->2 two cycles after lock; RUN, SYS_RSTN=1 and PLL_READY=1 after 8 stable cycles; RETRY_CNT=0.
2. Single timeout: PLL_LOCK held low for the first attempt, raised during the second -> one RESET_PLL re-entry with PLL_RESETB low 4 cycles; RETRY_CNT=1 until RUN, then 0.
3. Permanent no-lock: PLL_LOCK=0 forever -> 3 attempts (RETRY_CNT 0,1,2), then STATE=4, FAULT=1, PLL_BYPASS=1, SYS_RSTN=1; state stays put for 200+ cycles.
4. Glitch filter in RUN: 2-cycle low pulse on PLL_LOCK -> stays in RUN, SYS_RSTN=1. A 3-cycle low pulse -> SYS_RSTN=0 and STATE=0 exactly 3 cycles after lock_s falls; relock returns to RUN.
5. Lock drop in STABILIZE at cycle 5 of 8 -> RESET_PLL, RETRY_CNT increments, no SYS_RSTN pulse.
6. Async reset mid-WAIT_LOCK and in FAULT: assert RESETB between clock edges -> outputs reach reset values without a clock edge; a full sequence restarts after release.

Source files
------------

// File: rtl/pll_seq_ctrl.sv
// pll_seq_ctrl: brings the PLL up from power-on, holds system reset until lock is trusted,
// retries on timeout and falls back to bypass once retries are exhausted.
module pll_seq_ctrl #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1200,
    parameter int unsigned STABLE_CYCLES  = 256,
    parameter int unsigned LOCK_FILT      = 4,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       CLK,
    input  logic       RESETB,
    input  logic       PLL_LOCK,
    output logic       PLL_RESETB,
    output logic       PLL_BYPASS,
    output logic       SYS_RSTN,
    output logic       PLL_READY,
    output logic       FAULT,
    output logic [1:0] RETRY_CNT,
    output logic [2:0] STATE
);
    localparam int unsigned M1   = PLL_RST_CYCLES > LOCK_TIMEOUT ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned M2   = STABLE_CYCLES > LOCK_FILT ? STABLE_CYCLES : LOCK_FILT;
    localparam int unsigned MAXP = M1 > M2 ? M1 : M2;
    localparam int unsigned CW   = $clog2(MAXP + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [1:0]    MAX_R     = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    retry_nxt;
    logic [1:0]    sync;
    logic          lock_s;
    logic          fail;

    assign lock_s    = sync[1];
    assign STATE     = state;

    always_comb begin
        nxt       = state;
        cnt_nxt   = cnt + CW'(1);
        retry_nxt = RETRY_CNT;
        fail      = 1'b0;
        case (state)
            S_RESET_PLL: if (cnt == RST_LAST) begin
                nxt     = S_WAIT_LOCK;
                cnt_nxt = '0;
            end
            S_WAIT_LOCK: if (lock_s) begin
                nxt     = S_STABILIZE;
                cnt_nxt = '0;
            end else if (cnt == TO_LAST) begin
                fail = 1'b1;
            end
            S_STABILIZE: if (!lock_s) begin
                fail = 1'b1;
            end else if (cnt == STB_LAST) begin
                nxt       = S_RUN;
                cnt_nxt   = '0;
                retry_nxt = '0;
            end
            S_RUN: if (lock_s) begin
                cnt_nxt = '0;
            end else if (cnt == FILT_LAST) begin
                nxt     = S_RESET_PLL;
                cnt_nxt = '0;
            end
            S_FAULT: cnt_nxt = cnt;
            default: begin
                nxt       = S_RESET_PLL;
                cnt_nxt   = '0;
                retry_nxt = '0;
            end
        endcase
        // a failed attempt either retries from RESET_PLL or gives up into bypass
        if (fail) begin
            cnt_nxt   = '0;
            nxt       = RETRY_CNT == MAX_R ? S_FAULT : S_RESET_PLL;
            retry_nxt = (RETRY_CNT == MAX_R || &RETRY_CNT) ? RETRY_CNT : RETRY_CNT + 2'd1;
        end
    end

    // outputs are decoded from the next state so they change on the same edge as STATE
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            sync       <= '0;
            state      <= S_RESET_PLL;
            cnt        <= '0;
            RETRY_CNT  <= '0;
            PLL_RESETB <= 1'b0;
            PLL_BYPASS <= 1'b0;
            SYS_RSTN   <= 1'b0;
            PLL_READY  <= 1'b0;
            FAULT      <= 1'b0;
        end else begin
            sync       <= {sync[0], PLL_LOCK};
            state      <= nxt;
            cnt        <= cnt_nxt;
            RETRY_CNT  <= retry_nxt;
            PLL_RESETB <= nxt == S_WAIT_LOCK || nxt == S_STABILIZE || nxt == S_RUN;
            PLL_BYPASS <= nxt == S_FAULT;
            SYS_RSTN   <= nxt == S_RUN || nxt == S_FAULT;
            PLL_READY  <= nxt == S_RUN;
            FAULT      <= nxt == S_FAULT;
        end
    end
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// tb_pll_seq_ctrl: directed vectors for pll_seq_ctrl with small timing parameters.
module tb_pll_seq_ctrl;
    logic       CLK = 1'b0;
    logic       RESETB;
    logic       PLL_LOCK;
    logic       PLL_RESETB, PLL_BYPASS, SYS_RSTN, PLL_READY, FAULT;
    logic [1:0] RETRY_CNT;
    logic [2:0] STATE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pll_seq_ctrl #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT(20),
        .STABLE_CYCLES(8),
        .LOCK_FILT(3),
        .MAX_RETRIES(2)
    ) dut (
        .CLK(CLK),
        .RESETB(RESETB),
        .PLL_LOCK(PLL_LOCK),
        .PLL_RESETB(PLL_RESETB),
        .PLL_BYPASS(PLL_BYPASS),
        .SYS_RSTN(SYS_RSTN),
        .PLL_READY(PLL_READY),
        .FAULT(FAULT),
        .RETRY_CNT(RETRY_CNT),
        .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       lock;
        int         n;
        logic [2:0] st;
        logic [1:0] rc;
    } vec_t;

    vec_t tv[$];

    // expected pin values per state: {PLL_RESETB, PLL_BYPASS, SYS_RSTN, PLL_READY, FAULT}
    function automatic logic [4:0] pins(input logic [2:0] st);
        return st == 3'd0 ? 5'b00000 :
               st == 3'd1 ? 5'b10000 :
               st == 3'd2 ? 5'b10000 :
               st == 3'd3 ? 5'b10110 : 5'b01101;
    endfunction

    task automatic ck(input string nm, input logic [2:0] st, input logic [1:0] rc);
        logic [9:0] got, exp;
        got = {STATE, PLL_RESETB, PLL_BYPASS, SYS_RSTN, PLL_READY, FAULT, RETRY_CNT};
        exp = {st, pins(st), rc};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d resetb/bypass/sysrstn/ready/fault=%b retry=%0d, want state=%0d pins=%b retry=%0d",
                     nm, got[9:7], got[6:2], got[1:0], st, pins(st), rc);
        end
    endtask

    task automatic rst(input logic lk);
        RESETB   = 1'b0;
        PLL_LOCK = lk;
        @(posedge CLK);
        #1;
        RESETB = 1'b1;
        cyc    = 0;
    endtask

    task automatic adv(input int to);
        repeat (to - cyc) @(posedge CLK);
        cyc = to;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // nominal bring-up, then RUN glitch filter and relock
        tv = '{
            '{1'b0, 3, 3'd0, 2'd0}, '{1'b0, 1, 3'd1, 2'd0}, '{1'b0, 5, 3'd1, 2'd0},
            '{1'b1, 2, 3'd1, 2'd0}, '{1'b1, 1, 3'd2, 2'd0}, '{1'b1, 7, 3'd2, 2'd0},
            '{1'b1, 1, 3'd3, 2'd0}, '{1'b1, 5, 3'd3, 2'd0},
            '{1'b0, 2, 3'd3, 2'd0}, '{1'b1, 5, 3'd3, 2'd0},
            '{1'b0, 3, 3'd3, 2'd0}, '{1'b1, 1, 3'd3, 2'd0}, '{1'b1, 1, 3'd0, 2'd0},
            '{1'b1, 3, 3'd0, 2'd0}, '{1'b1, 1, 3'd1, 2'd0}, '{1'b1, 1, 3'd2, 2'd0},
            '{1'b1, 7, 3'd2, 2'd0}, '{1'b1, 1, 3'd3, 2'd0}
        };
        RESETB   = 1'b0;
        PLL_LOCK = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        ck("reset", 3'd0, 2'd0);
        RESETB = 1'b1;
        for (int i = 0; i < tv.size(); i++) begin
            PLL_LOCK = tv[i].lock;
            repeat (tv[i].n) @(posedge CLK);
            #1;
            ck($sformatf("vec%0d", i), tv[i].st, tv[i].rc);
        end

        // single timeout then lock on the second attempt
        rst(1'b0);
        adv(23); ck("to1_wait", 3'd1, 2'd0);
        adv(24); ck("to1_retry", 3'd0, 2'd1);
        adv(27); ck("to1_rst_low", 3'd0, 2'd1);
        adv(28); ck("to1_wait2", 3'd1, 2'd1);
        adv(30); PLL_LOCK = 1'b1;
        adv(32); ck("to1_sync", 3'd1, 2'd1);
        adv(33); ck("to1_stab", 3'd2, 2'd1);
        adv(40); ck("to1_stab_end", 3'd2, 2'd1);
        adv(41); ck("to1_run", 3'd3, 2'd0);

        // lock drop on the fifth STABILIZE cycle
        rst(1'b0);
        adv(9); PLL_LOCK = 1'b1;
        adv(12); ck("drop_stab", 3'd2, 2'd0);
        adv(14); PLL_LOCK = 1'b0;
        adv(16); ck("drop_pre", 3'd2, 2'd0);
        adv(17); ck("drop_retry", 3'd0, 2'd1);
        adv(21); ck("drop_wait", 3'd1, 2'd1);

        // permanent no-lock ends in FAULT
        rst(1'b0);
        adv(47); ck("nl_wait2", 3'd1, 2'd1);
        adv(48); ck("nl_retry2", 3'd0, 2'd2);
        adv(71); ck("nl_wait3", 3'd1, 2'd2);
        adv(72); ck("nl_fault", 3'd4, 2'd2);
        PLL_LOCK = 1'b1;
        adv(300); ck("nl_fault_hold", 3'd4, 2'd2);

        // async reset from FAULT without a clock edge
        #3 RESETB = 1'b0;
        #1 ck("async_fault", 3'd0, 2'd0);

        // async reset mid-WAIT_LOCK, then a full restart with lock present
        rst(1'b0);
        adv(10); ck("mid_wait", 3'd1, 2'd0);
        #3 RESETB = 1'b0;
        #1 ck("async_wait", 3'd0, 2'd0);
        rst(1'b1);
        adv(3); ck("re_rst", 3'd0, 2'd0);
        adv(4); ck("re_wait", 3'd1, 2'd0);
        adv(5); ck("re_stab", 3'd2, 2'd0);
        adv(12); ck("re_stab_end", 3'd2, 2'd0);
        adv(13); ck("re_run", 3'd3, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
